// File: rtl/perceptron_pkg.sv
// perceptron_pkg: shared types, widths and index helpers for the accumulator dump sequencer.
// The CSUM state only exists when ACC_DUMP_CSUM_EN is defined.
package perceptron_pkg;
  localparam int SEL_W  = 4;
  localparam int BYTE_W = 8;
  localparam int TO_W   = 10;
  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    SEND,
    WAIT_HI,
    WAIT_LO,
`ifdef ACC_DUMP_CSUM_EN
    CSUM,
`endif
    FIN
  } state_e;
  function automatic logic [SEL_W-1:0] first_idx(input bit msb_first, input int nbytes);
    return msb_first ? SEL_W'(nbytes - 1) : '0;
  endfunction
  function automatic logic [SEL_W-1:0] last_idx(input bit msb_first, input int nbytes);
    return msb_first ? '0 : SEL_W'(nbytes - 1);
  endfunction
endpackage

// File: rtl/acc_dump_timeout.sv
// dump_timeout: counts cycles waiting for busy_tx to rise; expired once the count reaches BUSY_TO.
module dump_timeout
  import perceptron_pkg::*;
#(
  parameter int BUSY_TO = 1023
) (
  input  logic clk,
  input  logic nRst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [TO_W-1:0] cnt_q, cnt_d;
  assign expired = cnt_q == TO_W'(BUSY_TO);
  always_comb cnt_d = clr ? '0 : (en && !expired) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk) begin
    if (!nRst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/acc_dump.sv
// acc_dump: steps the accumulator byte mux through NBYTES bytes and paces them into the UART.
// Define ACC_DUMP_CSUM_EN to append a mod-256 checksum frame after the data bytes.
module acc_dump
  import perceptron_pkg::*;
#(
  parameter int NBYTES    = 16,
  parameter bit MSB_FIRST = 1'b0,
  parameter int BUSY_TO   = 1023
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic              start,
  input  logic [BYTE_W-1:0] mux_data,
  input  logic              busy_tx,
  output logic [SEL_W-1:0]  sel,
  output logic              transmit,
  output logic [BYTE_W-1:0] data_tx,
  output logic              active,
  output logic              done,
  output logic              err
);
  localparam logic [SEL_W-1:0] FIRST = first_idx(MSB_FIRST, NBYTES);
  localparam logic [SEL_W-1:0] LAST  = last_idx(MSB_FIRST, NBYTES);
  state_e            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [BYTE_W-1:0] data_tx_q, data_tx_d;
  logic              transmit_q, transmit_d;
  logic              active_q, active_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              expired;
`ifdef ACC_DUMP_CSUM_EN
  logic [BYTE_W-1:0] sum_q, sum_d;
  logic              csum_sent_q, csum_sent_d;
`endif
  dump_timeout #(.BUSY_TO(BUSY_TO)) u_timeout (
    .clk     (clk),
    .nRst    (nRst),
    .clr     (state_q == SEND),
    .en      (state_q == WAIT_HI),
    .expired (expired)
  );
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    data_tx_d = data_tx_q;
    active_d  = active_q;
    err_d     = err_q;
    done_d    = 1'b0;
`ifdef ACC_DUMP_CSUM_EN
    sum_d       = sum_q;
    csum_sent_d = csum_sent_q;
`endif
    case (state_q)
      IDLE: if (start) begin
        state_d  = SETTLE;
        active_d = 1'b1;
        err_d    = 1'b0;
        sel_d    = FIRST;
`ifdef ACC_DUMP_CSUM_EN
        sum_d       = '0;
        csum_sent_d = 1'b0;
`endif
      end
      SETTLE: if (!busy_tx) begin
        data_tx_d = mux_data;
        state_d   = SEND;
`ifdef ACC_DUMP_CSUM_EN
        sum_d = sum_q + mux_data;
`endif
      end
      SEND: state_d = WAIT_HI;
      WAIT_HI: begin
        if (busy_tx) state_d = WAIT_LO;
        else if (expired) begin
          err_d   = 1'b1;
          state_d = FIN;
        end
      end
      WAIT_LO: if (!busy_tx) begin
        if (sel_q == LAST) begin
`ifdef ACC_DUMP_CSUM_EN
          state_d = csum_sent_q ? FIN : CSUM;
`else
          state_d = FIN;
`endif
        end else begin
          sel_d   = MSB_FIRST ? sel_q - 1'b1 : sel_q + 1'b1;
          state_d = SETTLE;
        end
      end
`ifdef ACC_DUMP_CSUM_EN
      CSUM: begin
        data_tx_d   = sum_q;
        csum_sent_d = 1'b1;
        state_d     = SEND;
      end
`endif
      FIN: begin
        active_d = 1'b0;
        done_d   = !err_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    transmit_d = state_d == SEND;
  end
  always_ff @(posedge clk) begin
    if (!nRst) begin
      state_q    <= IDLE;
      sel_q      <= FIRST;
      data_tx_q  <= '0;
      transmit_q <= 1'b0;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef ACC_DUMP_CSUM_EN
      sum_q       <= '0;
      csum_sent_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      data_tx_q  <= data_tx_d;
      transmit_q <= transmit_d;
      active_q   <= active_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef ACC_DUMP_CSUM_EN
      sum_q       <= sum_d;
      csum_sent_q <= csum_sent_d;
`endif
    end
  end
  assign sel      = sel_q;
  assign transmit = transmit_q;
  assign data_tx  = data_tx_q;
  assign active   = active_q;
  assign done     = done_q;
  assign err      = err_q;
endmodule

// File: tb/tb_acc_dump.sv
// tb_acc_dump: randomized dumps on three acc_dump configurations against a frame-list model.
module tb_acc_dump;
  logic clk = 1'b0;
  logic nRst;
  logic [127:0] acc;
  logic busy_tx;
  logic [2:0] start_v;
  wire  [2:0] transmit_v, active_v, done_v, err_v;
  wire  [3:0] sel_v [3];
  wire  [7:0] data_v [3];
  wire  [7:0] mux_v [3];
  always #5 clk = ~clk;
  assign mux_v[0] = acc[{sel_v[0], 3'b000} +: 8];
  assign mux_v[1] = acc[{sel_v[1], 3'b000} +: 8];
  assign mux_v[2] = acc[{sel_v[2], 3'b000} +: 8];
  acc_dump #(.NBYTES(16), .MSB_FIRST(1'b0), .BUSY_TO(1023)) u0 (
    .clk(clk), .nRst(nRst), .start(start_v[0]), .mux_data(mux_v[0]), .busy_tx(busy_tx),
    .sel(sel_v[0]), .transmit(transmit_v[0]), .data_tx(data_v[0]), .active(active_v[0]),
    .done(done_v[0]), .err(err_v[0]));
  acc_dump #(.NBYTES(16), .MSB_FIRST(1'b1), .BUSY_TO(1023)) u1 (
    .clk(clk), .nRst(nRst), .start(start_v[1]), .mux_data(mux_v[1]), .busy_tx(busy_tx),
    .sel(sel_v[1]), .transmit(transmit_v[1]), .data_tx(data_v[1]), .active(active_v[1]),
    .done(done_v[1]), .err(err_v[1]));
  acc_dump #(.NBYTES(1), .MSB_FIRST(1'b0), .BUSY_TO(1023)) u2 (
    .clk(clk), .nRst(nRst), .start(start_v[2]), .mux_data(mux_v[2]), .busy_tx(busy_tx),
    .sel(sel_v[2]), .transmit(transmit_v[2]), .data_tx(data_v[2]), .active(active_v[2]),
    .done(done_v[2]), .err(err_v[2]));

  // UART stand-in: busy rises dly cycles after a transmit and stays high len cycles
  logic stuck, force_hi;
  int dly, len, ph, cnt;
  always @(posedge clk) begin
    if (!nRst) begin
      busy_tx <= 1'b0; ph <= 0; cnt <= 0;
    end else if (force_hi) begin
      busy_tx <= 1'b1; ph <= 0;
    end else if (ph == 0) begin
      busy_tx <= 1'b0;
      if (|transmit_v && !stuck) begin ph <= 1; cnt <= dly; end
    end else if (ph == 1) begin
      if (cnt <= 1) begin busy_tx <= 1'b1; ph <= 2; cnt <= len; end
      else cnt <= cnt - 1;
    end else begin
      if (cnt <= 1) begin busy_tx <= 1'b0; ph <= 0; end
      else cnt <= cnt - 1;
    end
  end

  logic [7:0] got [$];
  logic [7:0] exp_q [$];
  int tx_cnt, done_cnt;
  always @(negedge clk) begin
    if (nRst) begin
      for (int k = 0; k < 3; k++) begin
        if (transmit_v[k]) begin got.push_back(data_v[k]); tx_cnt++; end
        if (done_v[k]) done_cnt++;
      end
    end
  end

  int checks = 0, failures = 0;
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] want);
    checks++;
    if (obs !== want) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, obs, want);
    end
  endtask

  function automatic void expect_frames(input int n, input bit msb);
    logic [7:0] s = 8'h00;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      int idx = msb ? n - 1 - i : i;
      logic [7:0] b = acc[idx*8 +: 8];
      exp_q.push_back(b);
      s = s + b;
    end
`ifdef ACC_DUMP_CSUM_EN
    exp_q.push_back(s);
`endif
  endfunction

  task automatic start_dump(input int k, input string tag);
    got.delete(); tx_cnt = 0; done_cnt = 0;
    @(negedge clk); start_v[k] = 1'b1;
    @(negedge clk); start_v[k] = 1'b0;
    check({tag, "_active_on_start"}, active_v[k], 1);
    check({tag, "_err_cleared"}, err_v[k], 0);
  endtask

  task automatic finish_dump(input int k, input int n, input bit msb, input string tag);
    int cyc = 0;
    while (active_v[k] && cyc < 20000) begin
      @(negedge clk); cyc++;
      start_v[k] = active_v[k] ? ($urandom_range(0, 15) == 0) : 1'b0;
    end
    start_v[k] = 1'b0;
    check({tag, "_ends_in_time"}, cyc < 20000, 1);
    repeat (3) @(negedge clk);
    expect_frames(n, msb);
    check({tag, "_frames"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), (i < got.size()) ? got[i] : 9'h1ff, exp_q[i]);
    check({tag, "_transmits"}, tx_cnt, exp_q.size());
    check({tag, "_done_once"}, done_cnt, 1);
    check({tag, "_err"}, err_v[k], 0);
    check({tag, "_active_off"}, active_v[k], 0);
    check({tag, "_sel_end"}, sel_v[k], msb ? 0 : n - 1);
  endtask

  task automatic run_dump(input int k, input int n, input bit msb, input string tag);
    dly = $urandom_range(1, 3); len = $urandom_range(1, 12);
    start_dump(k, tag);
    finish_dump(k, n, msb, tag);
  endtask

  initial begin
    int cyc;
    start_v = '0; stuck = 0; force_hi = 0; dly = 1; len = 10;
    acc = {$urandom, $urandom, $urandom, $urandom};
    nRst = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst%0d_sel", k), sel_v[k], (k == 1) ? 15 : 0);
      check($sformatf("rst%0d_outs", k),
            {transmit_v[k], active_v[k], done_v[k], err_v[k], data_v[k]}, 0);
    end
    nRst = 1'b1;
    acc = 128'h0f0e0d0c0b0a09080706050403020100;
    start_dump(0, "lsb_seq"); finish_dump(0, 16, 0, "lsb_seq");
    start_dump(1, "msb_seq"); finish_dump(1, 16, 1, "msb_seq");
    for (int r = 0; r < 4; r++) begin
      acc = {$urandom, $urandom, $urandom, $urandom};
      run_dump(r % 3, (r % 3 == 2) ? 1 : 16, r % 3 == 1, $sformatf("rand%0d", r));
    end
    // transmitter never answers: a single frame, then timeout
    stuck = 1;
    start_dump(0, "tmo");
    cyc = 0;
    while (tx_cnt == 0 && cyc < 100) begin @(negedge clk); cyc++; end
    repeat (1000) @(negedge clk);
    check("tmo_err_not_early", err_v[0], 0);
    check("tmo_active_waiting", active_v[0], 1);
    cyc = 0;
    while (active_v[0] && cyc < 60) begin @(negedge clk); cyc++; end
    repeat (5) @(negedge clk);
    check("tmo_err_set", err_v[0], 1);
    check("tmo_active_off", active_v[0], 0);
    check("tmo_no_done", done_cnt, 0);
    check("tmo_one_transmit", tx_cnt, 1);
    stuck = 0;
    // busy already high at start: hold in SETTLE until it falls
    acc = {$urandom, $urandom, $urandom, $urandom};
    dly = 2; len = 10;
    @(negedge clk); force_hi = 1;
    repeat (2) @(negedge clk);
    start_dump(0, "busy_at_start");
    repeat (20) @(negedge clk);
    check("busy_at_start_no_tx", tx_cnt, 0);
    force_hi = 0;
    @(negedge clk); check("busy_release_wait", transmit_v[0], 0);
    @(negedge clk); check("busy_release_tx", transmit_v[0], 1);
    check("busy_release_byte", data_v[0], acc[7:0]);
    finish_dump(0, 16, 0, "busy_at_start");
    // reset mid-dump, then a fresh dump from byte 0
    start_dump(0, "midrst");
    cyc = 0;
    while (got.size() < 6 && cyc < 2000) begin @(negedge clk); cyc++; end
    nRst = 1'b0;
    @(negedge clk);
    check("midrst_sel", sel_v[0], 0);
    check("midrst_outs", {transmit_v[0], active_v[0], done_v[0], err_v[0], data_v[0]}, 0);
    nRst = 1'b1;
    repeat (5) @(negedge clk);
    check("midrst_no_done", done_cnt, 0);
    run_dump(0, 16, 0, "after_rst");
    acc = {16{8'h11}};
    run_dump(0, 16, 0, "ones_a");
    run_dump(0, 16, 0, "ones_b");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
